// File: rtl/uart_bus_loader_pkg.sv
// Shared constants and state encoding for the UART bus loader.
package uart_bus_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_HALT  = 8'h48;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  localparam int BYTE_CNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/uart_bus_loader_resp_ser.sv
// Reply serializer: sends a 1- or 4-byte reply LSB first over a valid/ready byte link.
module loader_resp_ser (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        len4,
  input  logic [31:0] word,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [23:0] pending;
  logic [1:0]  remaining;

  // remaining counts bytes still queued behind the one currently on tx_data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      pending   <= 24'h0;
      remaining <= 2'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        tx_valid  <= 1'b1;
        tx_data   <= word[7:0];
        pending   <= word[31:8];
        remaining <= len4 ? 2'd3 : 2'd0;
      end else if (tx_valid && tx_ready) begin
        if (remaining == 2'd0) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end else begin
          tx_data   <= pending[7:0];
          pending   <= {8'h00, pending[23:8]};
          remaining <= remaining - 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_bus_loader.sv
// Debug/boot bus initiator: parses UART commands, issues word bus accesses, owns CPU run control.
module uart_bus_loader
  import uart_bus_loader_pkg::*;
#(
  parameter logic [23:0] BYTE_TIMEOUT = 24'd2_000_000,
  parameter logic [15:0] BUS_TIMEOUT  = 16'd1024,
  parameter logic        RUN_AT_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_run,
  output logic        overrun
);

  state_t                state;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  is_write;
  logic [31:0]           addr_sh;
  logic [31:0]           data_sh;
  logic [23:0]           byte_timer;
  logic [15:0]           bus_timer;
  logic                  resp_load;
  logic                  resp_len4;
  logic [31:0]           resp_word;
  logic                  resp_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      is_write   <= 1'b0;
      addr_sh    <= 32'h0;
      data_sh    <= 32'h0;
      byte_timer <= 24'h0;
      bus_timer  <= 16'h0;
      resp_load  <= 1'b0;
      resp_len4  <= 1'b0;
      resp_word  <= 32'h0;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
      cpu_run    <= RUN_AT_RESET;
      overrun    <= 1'b0;
    end else begin
      resp_load <= 1'b0;
      if (rx_valid && (state == ST_BUS || state == ST_RESP))
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            byte_cnt   <= '0;
            byte_timer <= 24'h0;
            case (rx_data)
              CMD_WRITE: begin
                is_write <= 1'b1;
                state    <= ST_ADDR;
              end
              CMD_READ: begin
                is_write <= 1'b0;
                state    <= ST_ADDR;
              end
              CMD_GO, CMD_HALT: begin
                cpu_run   <= (rx_data == CMD_GO);
                resp_word <= {24'h0, RSP_OK};
                resp_len4 <= 1'b0;
                resp_load <= 1'b1;
                state     <= ST_RESP;
              end
              default: begin
                resp_word <= {24'h0, RSP_UNK};
                resp_len4 <= 1'b0;
                resp_load <= 1'b1;
                state     <= ST_RESP;
              end
            endcase
          end
        end

        // A byte landing on the expiry cycle still counts and restarts the timer
        ST_ADDR, ST_DATA: begin
          if (rx_valid) begin
            byte_timer <= 24'h0;
            byte_cnt   <= byte_cnt + 1'b1;
            if (state == ST_ADDR)
              addr_sh <= {rx_data, addr_sh[31:8]};
            else
              data_sh <= {rx_data, data_sh[31:8]};
            if (&byte_cnt)
              state <= (state == ST_ADDR && is_write) ? ST_DATA : ST_BUS;
          end else if (byte_timer == BYTE_TIMEOUT - 24'd1) begin
            state <= ST_IDLE;
          end else begin
            byte_timer <= byte_timer + 24'd1;
          end
        end

        ST_BUS: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= addr_sh & 32'hFFFF_FFFC;
            mem_wstrb <= is_write ? 4'hF : 4'h0;
            if (is_write)
              mem_wdata <= data_sh;
            bus_timer <= 16'h0;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            resp_word <= is_write ? {24'h0, RSP_OK} : mem_rdata;
            resp_len4 <= !is_write;
            resp_load <= 1'b1;
            state     <= ST_RESP;
          end else if (bus_timer == BUS_TIMEOUT - 16'd1) begin
            mem_valid <= 1'b0;
            resp_word <= {24'h0, RSP_ERR};
            resp_len4 <= 1'b0;
            resp_load <= 1'b1;
            state     <= ST_RESP;
          end else begin
            bus_timer <= bus_timer + 16'd1;
          end
        end

        ST_RESP: begin
          if (resp_done)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  loader_resp_ser u_resp_ser (
    .clk      (clk),
    .resetn   (resetn),
    .load     (resp_load),
    .len4     (resp_len4),
    .word     (resp_word),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .done     (resp_done)
  );

endmodule

// File: tb/tb_uart_bus_loader.sv
// Bench for uart_bus_loader: directed vector table, randomized commands against a command-level model, corner sequences.
module tb_uart_bus_loader;

  localparam logic [23:0] BT     = 24'd40;
  localparam logic [15:0] BUS_TO = 16'd16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_run;
  logic        overrun;

  uart_bus_loader #(
    .BYTE_TIMEOUT (BT),
    .BUS_TIMEOUT  (BUS_TO),
    .RUN_AT_RESET (1'b0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .cpu_run   (cpu_run),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [71:0] cmd;
    int          n;
    int          delay;
    logic [31:0] rdata;
    int          exp_len;
    logic [31:0] exp_reply;
    int          exp_txn;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    int          e_hi;
    logic        chk_wd;
    logic        e_run;
  } vec_t;

  vec_t vecs[11];

  int total = 0;
  int bad = 0;
  logic [7:0] got[$];

  // bus responder state
  int          resp_delay = 1;
  logic [31:0] resp_rdata = 32'h0;
  int          hi_cnt = 0;
  int          txn_count = 0;
  int          bus_unstable = 0;
  logic [31:0] snap_addr, snap_wdata, last_addr, last_wdata;
  logic [3:0]  snap_wstrb, last_wstrb;
  int          last_hi = 0;

  // transmit sink state
  int          stall_left = 0;
  bit          stall_arm = 0;
  bit          prev_pending = 0;
  logic [7:0]  prev_data = 8'h00;
  int          tx_unstable = 0;
  int          stall_seen = 0;

  // Responder: raises mem_ready after resp_delay cycles of mem_valid (0 = never), logs each transaction
  always @(negedge clk) begin
    if (!resetn) begin
      hi_cnt    = 0;
      mem_ready = 1'b0;
    end else if (mem_valid) begin
      if (hi_cnt == 0) begin
        snap_addr  = mem_addr;
        snap_wdata = mem_wdata;
        snap_wstrb = mem_wstrb;
      end else if (mem_addr !== snap_addr || mem_wdata !== snap_wdata || mem_wstrb !== snap_wstrb) begin
        bus_unstable++;
      end
      hi_cnt++;
      if (resp_delay != 0 && hi_cnt == resp_delay) begin
        mem_ready = 1'b1;
        mem_rdata = resp_rdata;
      end
    end else begin
      if (hi_cnt > 0) begin
        txn_count++;
        last_addr  = snap_addr;
        last_wdata = snap_wdata;
        last_wstrb = snap_wstrb;
        last_hi    = hi_cnt;
        hi_cnt     = 0;
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom();
    end
  end

  // Sink: collects reply bytes, applies scripted backpressure, checks held bytes stay stable
  always @(negedge clk) begin
    if (!resetn) begin
      prev_pending = 0;
      stall_left   = 0;
      tx_ready     = 1'b1;
    end else begin
      if (prev_pending && (!tx_valid || tx_data !== prev_data))
        tx_unstable++;
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && !tx_ready)
        stall_seen++;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        prev_pending = 0;
        if (stall_arm && got.size() == 1) begin
          stall_left = 10;
          stall_arm  = 0;
        end
      end else begin
        prev_pending = tx_valid;
        prev_data    = tx_data;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom());
    repeat (gap) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [71:0] cmd, input int n, input int gap);
    for (int i = 0; i < n; i++)
      sendByte(cmd[8*i +: 8], gap);
  endtask

  task automatic waitIdle(input int exp_len);
    for (int i = 0; i < 400; i++) begin
      if (got.size() >= exp_len && !mem_valid && !tx_valid)
        break;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [31:0] packReply();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < got.size() && i < 4; i++)
      w[8*i +: 8] = got[i];
    return w;
  endfunction

  task automatic runCheck(input vec_t v, input int gap);
    int t0;
    t0 = txn_count;
    got.delete();
    resp_delay = v.delay;
    resp_rdata = v.rdata;
    applyStimulus(v.cmd, v.n, gap);
    waitIdle(v.exp_len);
    checkOutput({v.name, "_len"}, got.size(), v.exp_len);
    checkOutput({v.name, "_reply"}, packReply(), v.exp_reply);
    checkOutput({v.name, "_txns"}, txn_count - t0, v.exp_txn);
    if (v.exp_txn > 0) begin
      checkOutput({v.name, "_addr"}, last_addr, v.e_addr);
      checkOutput({v.name, "_wstrb"}, last_wstrb, v.e_wstrb);
      checkOutput({v.name, "_hi"}, last_hi, v.e_hi);
      if (v.chk_wd)
        checkOutput({v.name, "_wdata"}, last_wdata, v.e_wdata);
    end
    checkOutput({v.name, "_run"}, cpu_run, v.e_run);
  endtask

  // Command-level reference model: derives reply and bus expectations from command semantics only
  task automatic randomPhase(inout logic model_run);
    vec_t        v;
    int          kind;
    int          dly;
    logic [31:0] a, d, rd;
    logic [7:0]  b;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 4);
      a    = $urandom();
      d    = $urandom();
      rd   = $urandom();
      dly  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4);
      v.name = "rnd";
      v.delay = dly;
      v.rdata = rd;
      v.exp_txn = 0;
      v.e_addr = a & 32'hFFFF_FFFC;
      v.e_wdata = d;
      v.e_wstrb = 4'h0;
      v.e_hi = (dly == 0) ? int'(BUS_TO) : dly;
      v.chk_wd = 1'b0;
      v.exp_len = 1;
      v.exp_reply = 32'h4B;
      case (kind)
        0: begin
          v.cmd = {d, a, 8'h57};
          v.n = 9;
          v.exp_txn = 1;
          v.e_wstrb = 4'hF;
          v.chk_wd = 1'b1;
          v.exp_reply = (dly == 0) ? 32'h45 : 32'h4B;
        end
        1: begin
          v.cmd = {32'h0, a, 8'h52};
          v.n = 5;
          v.exp_txn = 1;
          v.exp_len = (dly == 0) ? 1 : 4;
          v.exp_reply = (dly == 0) ? 32'h45 : rd;
        end
        2: begin
          v.cmd = 72'h47;
          v.n = 1;
          model_run = 1'b1;
        end
        3: begin
          v.cmd = 72'h48;
          v.n = 1;
          model_run = 1'b0;
        end
        default: begin
          b = 8'($urandom_range(0, 255));
          while (b == 8'h57 || b == 8'h52 || b == 8'h47 || b == 8'h48)
            b = 8'($urandom_range(0, 255));
          v.cmd = {64'h0, b};
          v.n = 1;
          v.exp_reply = 32'h3F;
        end
      endcase
      v.e_run = model_run;
      runCheck(v, $urandom_range(0, 6));
    end
  endtask

  initial begin
    vec_t v;
    int   t0;
    int   us0;
    int   ss0;
    logic model_run;

    vecs[0]  = '{"write",    72'hDEADBEEF_00000100_57, 9, 2, 32'h0,        1, 32'h4B,       1, 32'h00000100, 32'hDEADBEEF, 4'hF, 2,  1'b1, 1'b0};
    vecs[1]  = '{"read",     72'h00000100_52,          5, 3, 32'h12345678, 4, 32'h12345678, 1, 32'h00000100, 32'h0,        4'h0, 3,  1'b0, 1'b0};
    vecs[2]  = '{"rd_tmo",   72'h80000000_52,          5, 0, 32'h0,        1, 32'h45,       1, 32'h80000000, 32'h0,        4'h0, 16, 1'b0, 1'b0};
    vecs[3]  = '{"go",       72'h47,                   1, 1, 32'h0,        1, 32'h4B,       0, 32'h0,        32'h0,        4'h0, 0,  1'b0, 1'b1};
    vecs[4]  = '{"go_again", 72'h47,                   1, 1, 32'h0,        1, 32'h4B,       0, 32'h0,        32'h0,        4'h0, 0,  1'b0, 1'b1};
    vecs[5]  = '{"halt",     72'h48,                   1, 1, 32'h0,        1, 32'h4B,       0, 32'h0,        32'h0,        4'h0, 0,  1'b0, 1'b0};
    vecs[6]  = '{"halt_again", 72'h48,                 1, 1, 32'h0,        1, 32'h4B,       0, 32'h0,        32'h0,        4'h0, 0,  1'b0, 1'b0};
    vecs[7]  = '{"unknown",  72'h00,                   1, 1, 32'h0,        1, 32'h3F,       0, 32'h0,        32'h0,        4'h0, 0,  1'b0, 1'b0};
    vecs[8]  = '{"wr_unal",  72'h11223344_00000203_57, 9, 1, 32'h0,        1, 32'h4B,       1, 32'h00000200, 32'h11223344, 4'hF, 1,  1'b1, 1'b0};
    vecs[9]  = '{"rd_unal",  72'h0000FFFF_52,          5, 1, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1, 32'h0000FFFC, 32'h0,        4'h0, 1,  1'b0, 1'b0};
    vecs[10] = '{"wr_tmo",   72'h0BADF00D_00000010_57, 9, 0, 32'h0,        1, 32'h45,       1, 32'h00000010, 32'h0BADF00D, 4'hF, 16, 1'b1, 1'b0};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_valid", mem_valid, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_wstrb", mem_wstrb, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_cpu_run", cpu_run, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++)
      runCheck(vecs[i], 1);

    model_run = 1'b0;
    randomPhase(model_run);
    v = vecs[5];
    runCheck(v, 0);

    // Partial command followed by silence is dropped without any bus or reply activity
    t0 = txn_count;
    got.delete();
    applyStimulus(72'h0057, 2, 0);
    repeat (60) @(negedge clk);
    checkOutput("abort_txns", txn_count - t0, 0);
    checkOutput("abort_len", got.size(), 0);
    v = vecs[3];
    v.name = "go_after_abort";
    runCheck(v, 0);
    v = vecs[5];
    runCheck(v, 0);

    // Bytes spaced exactly at the timeout limit still land; one cycle later the command is lost
    v = vecs[1];
    v.name = "gap_edge";
    v.cmd = 72'h00000400_52;
    v.rdata = 32'h5A5AA5A5;
    v.exp_reply = 32'h5A5AA5A5;
    v.e_addr = 32'h00000400;
    runCheck(v, int'(BT) - 1);
    v = vecs[3];
    v.name = "gap_late";
    v.cmd = 72'h4757;
    v.n = 2;
    runCheck(v, int'(BT));
    v = vecs[5];
    runCheck(v, 0);

    // Backpressure mid-reply plus a byte injected while the reply is in flight
    checkOutput("ovr_before", overrun, 0);
    t0 = txn_count;
    us0 = tx_unstable;
    ss0 = stall_seen;
    got.delete();
    resp_delay = 2;
    resp_rdata = 32'hA1B2C3D4;
    stall_arm = 1;
    applyStimulus(72'h00000800_52, 5, 0);
    for (int i = 0; i < 200 && got.size() < 1; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    applyStimulus(72'h55, 1, 0);
    waitIdle(4);
    checkOutput("bp_len", got.size(), 4);
    checkOutput("bp_reply", packReply(), 32'hA1B2C3D4);
    checkOutput("bp_txns", txn_count - t0, 1);
    checkOutput("bp_stall_cycles", stall_seen - ss0, 10);
    checkOutput("bp_tx_stable", tx_unstable - us0, 0);
    checkOutput("ovr_after", overrun, 1);

    // Reset asserted mid-transaction kills bus and transmit outputs at once
    v = vecs[3];
    runCheck(v, 0);
    got.delete();
    resp_delay = 0;
    applyStimulus(72'h00000100_52, 5, 0);
    for (int i = 0; i < 50 && !mem_valid; i++)
      @(negedge clk);
    checkOutput("rstbus_entered", mem_valid, 1);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("rstbus_mem_valid", mem_valid, 0);
    checkOutput("rstbus_tx_valid", tx_valid, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("rstbus_no_reply", got.size(), 0);
    checkOutput("rstbus_overrun", overrun, 0);
    checkOutput("rstbus_cpu_run", cpu_run, 0);
    checkOutput("rstbus_mem_addr", mem_addr, 0);
    checkOutput("rstbus_mem_wstrb", mem_wstrb, 0);
    v = vecs[0];
    v.name = "write_after_rst";
    runCheck(v, 0);

    checkOutput("bus_stable", bus_unstable, 0);
    checkOutput("tx_stable", tx_unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
